// File: rtl/pixel_scan_ctrl.sv
// Raster-scan address sequencer for the banked pixel store.
// Emits one bank/row/column address beat per valid/ready transfer, with optional line blanking.
module pixel_scan_ctrl #(
  parameter int H_ACTIVE      = 1448,
  parameter int V_ACTIVE      = 1072,
  parameter int ROWS_PER_BANK = 67,
  parameter int NUM_BANKS     = 16,
  parameter int HBLANK        = 0
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        cont_mode,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [3:0]  bank_sel,
  output logic [6:0]  bank_row,
  output logic [11:0] pix_row,
  output logic [11:0] pix_col,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  generate
    if (NUM_BANKS * ROWS_PER_BANK != V_ACTIVE) begin : g_geom_err
      $error("pixel_scan_ctrl: NUM_BANKS*ROWS_PER_BANK must equal V_ACTIVE");
    end
  endgenerate

  localparam int HBW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [HBW-1:0] HB_LAST   = HBW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [11:0]    COL_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0]    ROW_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [6:0]     BROW_LAST = 7'(ROWS_PER_BANK - 1);
  // Flags of the all-zero address, loaded whenever a frame (re)starts
  localparam logic ZERO_EOL = (H_ACTIVE == 1);
  localparam logic ZERO_EOF = (H_ACTIVE == 1) && (V_ACTIVE == 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HBLANK} state_t;
  state_t state;

  logic [HBW-1:0] hb_cnt;
  logic [11:0]    col_n, row_n;
  logic [6:0]     brow_n;
  logic [3:0]     bank_n;
  logic           line_end, last_pix;

  // Next address; only consumed when the current beat is not the final pixel
  always_comb begin
    line_end = (pix_col == COL_LAST);
    last_pix = line_end && (pix_row == ROW_LAST);
    col_n    = pix_col + 12'd1;
    row_n    = pix_row;
    brow_n   = bank_row;
    bank_n   = bank_sel;
    if (line_end) begin
      col_n = '0;
      row_n = pix_row + 12'd1;
      if (bank_row == BROW_LAST) begin
        brow_n = '0;
        bank_n = bank_sel + 4'd1;
      end else begin
        brow_n = bank_row + 7'd1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; rd_valid <= 1'b0; busy <= 1'b0;
      sof <= 1'b0; eol <= 1'b0; eof <= 1'b0;
      bank_sel <= '0; bank_row <= '0; pix_row <= '0; pix_col <= '0;
      frame_cnt <= '0; hb_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE; rd_valid <= 1'b0; busy <= 1'b0;
      sof <= 1'b0; eol <= 1'b0; eof <= 1'b0;
      bank_sel <= '0; bank_row <= '0; pix_row <= '0; pix_col <= '0;
      hb_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_SCAN; rd_valid <= 1'b1; busy <= 1'b1;
          sof <= 1'b1; eol <= ZERO_EOL; eof <= ZERO_EOF;
        end
        S_SCAN: if (rd_ready) begin
          hb_cnt <= '0;
          if (last_pix) begin
            frame_cnt <= frame_cnt + 16'd1;
            bank_sel <= '0; bank_row <= '0; pix_row <= '0; pix_col <= '0;
            sof <= 1'b1; eol <= ZERO_EOL; eof <= ZERO_EOF;
            if (!cont_mode) begin
              state <= S_IDLE; rd_valid <= 1'b0; busy <= 1'b0;
              sof <= 1'b0; eol <= 1'b0; eof <= 1'b0;
            end else if (HBLANK > 0) begin
              state <= S_HBLANK; rd_valid <= 1'b0;
            end
          end else begin
            pix_col <= col_n; pix_row <= row_n; bank_row <= brow_n; bank_sel <= bank_n;
            sof <= (col_n == 12'd0) && (row_n == 12'd0);
            eol <= (col_n == COL_LAST);
            eof <= (col_n == COL_LAST) && (row_n == ROW_LAST);
            if (line_end && HBLANK > 0) begin
              state <= S_HBLANK; rd_valid <= 1'b0;
            end
          end
        end
        S_HBLANK: begin
          if (hb_cnt == HB_LAST) begin
            state <= S_SCAN; rd_valid <= 1'b1;
          end else begin
            hb_cnt <= hb_cnt + HBW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl on a reduced 8x6 raster (2 banks x 3 rows),
// one instance without and one with 4-cycle line blanking.
module tb_pixel_scan_ctrl;
  localparam int H = 8, V = 6, RPB = 3, NB = 2;

  logic clk50 = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, cont_mode = 1'b0, rd_ready = 1'b0;

  logic        d0_rd_valid, d0_sof, d0_eol, d0_eof, d0_busy;
  logic [3:0]  d0_bank_sel;
  logic [6:0]  d0_bank_row;
  logic [11:0] d0_pix_row, d0_pix_col;
  logic [15:0] d0_frame_cnt;
  logic        d1_rd_valid, d1_sof, d1_eol, d1_eof, d1_busy;
  logic [3:0]  d1_bank_sel;
  logic [6:0]  d1_bank_row;
  logic [11:0] d1_pix_row, d1_pix_col;
  logic [15:0] d1_frame_cnt;

  int n_vec = 0, n_err = 0;

  always #10 clk50 = ~clk50;

  pixel_scan_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ROWS_PER_BANK(RPB), .NUM_BANKS(NB), .HBLANK(0)) dut0 (
    .clk50(clk50), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
    .rd_ready(rd_ready), .rd_valid(d0_rd_valid), .bank_sel(d0_bank_sel), .bank_row(d0_bank_row),
    .pix_row(d0_pix_row), .pix_col(d0_pix_col), .sof(d0_sof), .eol(d0_eol), .eof(d0_eof),
    .busy(d0_busy), .frame_cnt(d0_frame_cnt));

  pixel_scan_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ROWS_PER_BANK(RPB), .NUM_BANKS(NB), .HBLANK(4)) dut1 (
    .clk50(clk50), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
    .rd_ready(rd_ready), .rd_valid(d1_rd_valid), .bank_sel(d1_bank_sel), .bank_row(d1_bank_row),
    .pix_row(d1_pix_row), .pix_col(d1_pix_col), .sof(d1_sof), .eol(d1_eol), .eof(d1_eof),
    .busy(d1_busy), .frame_cnt(d1_frame_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  initial begin
    int beats, gap, frames, restarts, cyc;
    logic chk_bank, seen, prev_eol, prev_eof;

    // Reset state
    #5;
    chk("rst rd_valid", d0_rd_valid, 0);
    chk("rst busy", d0_busy, 0);
    chk("rst sof", d0_sof, 0);
    chk("rst pix_col", d0_pix_col, 0);
    chk("rst frame_cnt", d0_frame_cnt, 0);
    tick(); rst_n = 1'b1; tick();
    chk("idle rd_valid", d0_rd_valid, 0);

    // Full frame, ready always high, with bank boundary check
    rd_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk("first beat valid", d0_rd_valid, 1);
    chk("first beat sof", d0_sof, 1);
    chk("first beat col", d0_pix_col, 0);
    beats = 0; chk_bank = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (chk_bank) begin
        chk("bank boundary bank_sel", d0_bank_sel, 1);
        chk("bank boundary bank_row", d0_bank_row, 0);
        chk("bank boundary pix_row", d0_pix_row, 3);
        chk("bank boundary pix_col", d0_pix_col, 0);
        chk_bank = 1'b0;
      end
      if (d0_rd_valid && rd_ready) begin
        beats++;
        chk("row invariant", d0_pix_row, d0_bank_sel * RPB + d0_bank_row);
        if (d0_pix_row == 2 && d0_pix_col == 7) chk_bank = 1'b1;
        if (d0_eof) begin
          seen = 1'b1;
          chk("eof row", d0_pix_row, V - 1);
          chk("eof col", d0_pix_col, H - 1);
        end
      end
      tick();
    end
    chk("eof reached", seen, 1);
    chk("beat count", beats, H * V);
    chk("post-frame busy", d0_busy, 0);
    chk("post-frame rd_valid", d0_rd_valid, 0);
    chk("frame_cnt after frame", d0_frame_cnt, 1);
    for (int i = 0; i < 100 && d1_busy; i++) tick();
    chk("hblank dut idle", d1_busy, 0);
    chk("hblank dut frame_cnt", d1_frame_cnt, 1);

    // Back-pressure hold
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("pre-stall col", d0_pix_col, 3);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall col held", d0_pix_col, 3);
      chk("stall valid held", d0_rd_valid, 1);
    end
    rd_ready = 1'b1; tick();
    chk("after stall col", d0_pix_col, 4);

    // Abort mid-frame
    for (int i = 0; i < 100 && d0_pix_row != 12'd2; i++) tick();
    chk("reached row 2", d0_pix_row, 2);
    abort = 1'b1; tick();
    chk("abort rd_valid", d0_rd_valid, 0);
    chk("abort busy", d0_busy, 0);
    chk("abort pix_row", d0_pix_row, 0);
    chk("abort pix_col", d0_pix_col, 0);
    chk("abort frame_cnt", d0_frame_cnt, 1);
    start = 1'b1; tick();
    chk("abort beats start", d0_rd_valid, 0);
    abort = 1'b0; tick(); start = 1'b0;
    chk("restart valid", d0_rd_valid, 1);
    chk("restart sof", d0_sof, 1);
    chk("restart col", d0_pix_col, 0);

    // Asynchronous reset mid-scan
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("async rst rd_valid", d0_rd_valid, 0);
    chk("async rst busy", d0_busy, 0);
    chk("async rst col", d0_pix_col, 0);
    chk("async rst frame_cnt", d0_frame_cnt, 0);
    #2; rst_n = 1'b1; tick();
    chk("idle after rst", d0_rd_valid, 0);

    // Blanking and continuous mode on the HBLANK=4 instance
    cont_mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
    gap = 0; frames = 0; restarts = 0; prev_eol = 1'b0; prev_eof = 1'b0;
    for (cyc = 0; cyc < 400 && restarts < 2; cyc++) begin
      if (d1_rd_valid) begin
        chk("hblank gap", gap, prev_eol ? 4 : 0);
        if (prev_eof) begin
          restarts++;
          chk("wrap sof", d1_sof, 1);
          chk("wrap row", d1_pix_row, 0);
          chk("wrap col", d1_pix_col, 0);
          chk("wrap frame_cnt", d1_frame_cnt, frames);
        end
        prev_eol = d1_eol; prev_eof = d1_eof;
        if (d1_eof) frames++;
        gap = 0;
      end else if (d1_busy) begin
        gap++;
      end
      tick();
    end
    chk("cont restarts", restarts, 2);
    cont_mode = 1'b0;
    for (int i = 0; i < 200 && d1_busy; i++) tick();
    chk("cont stop idle", d1_busy, 0);
    chk("cont frame_cnt", d1_frame_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
